status_reg: RTL and testbench

//  6502 processor status register (P = N V 1 B D I Z C), directly downstream of the ALU.

---
 rtl/status_reg_if.sv | 44 ++++
 rtl/status_reg.sv | 123 ++++++++++++
 tb/tb_status_reg.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/status_reg_if.sv
// Bus between the 6502 control/ALU side and the processor status register.
interface status_reg_if;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned DATA_W = 8;

  logic                alu_zero;
  logic                alu_negative;
  logic                alu_overflow;
  logic                alu_c_out;
  logic [FLAG_W-1:0]   flag_upd;
  logic                ld_p;
  logic [DATA_W-1:0]   db_in;
  logic                set_c;
  logic                clr_c;
  logic                set_i;
  logic                clr_i;
  logic                set_d;
  logic                clr_d;
  logic                clr_v;
  logic                push_b;
  logic [1:0]          cond_sel;
  logic                cond_val;
  logic [DATA_W-1:0]   p_out;
  logic                c_in;
  logic                bcd;
  logic                irq_mask;
  logic                branch_taken;

  // Control/ALU side
  modport master (
    output alu_zero, alu_negative, alu_overflow, alu_c_out, flag_upd,
    output ld_p, db_in, set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v,
    output push_b, cond_sel, cond_val,
    input  p_out, c_in, bcd, irq_mask, branch_taken
  );

  // Status register side
  modport slave (
    input  alu_zero, alu_negative, alu_overflow, alu_c_out, flag_upd,
    input  ld_p, db_in, set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v,
    input  push_b, cond_sel, cond_val,
    output p_out, c_in, bcd, irq_mask, branch_taken
  );
endinterface

// File: rtl/status_reg.sv
// 6502 processor status register P = {N,V,1,B,D,I,Z,C}.
// Each flag resolves independently: bus load > set > clr > ALU capture > hold.
module status_reg #(
  parameter bit          CLR_D_ON_RESET = 1'b1,
  parameter int unsigned I_MASK_DELAY   = 1
) (
  input logic         clk,
  input logic         reset_n,
  status_reg_if.slave bus
);

  localparam int unsigned UPD_N = 3;
  localparam int unsigned UPD_V = 2;
  localparam int unsigned UPD_Z = 1;
  localparam int unsigned UPD_C = 0;

  logic n_q, n_d;
  logic v_q, v_d;
  logic d_q, d_d;
  logic i_q, i_d;
  logic z_q, z_d;
  logic c_q, c_d;

  // Bits 5:4 of the bus byte have no storage in P
  logic unused_db;
  assign unused_db = ^bus.db_in[5:4];

  // Per-flag next-state resolution
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (bus.ld_p) begin
      n_d = bus.db_in[7];
      v_d = bus.db_in[6];
      d_d = bus.db_in[3];
      i_d = bus.db_in[2];
      z_d = bus.db_in[1];
      c_d = bus.db_in[0];
    end else begin
      if (bus.flag_upd[UPD_N]) n_d = bus.alu_negative;

      if (bus.clr_v)                   v_d = 1'b0;
      else if (bus.flag_upd[UPD_V])    v_d = bus.alu_overflow;

      if (bus.set_d)                   d_d = 1'b1;
      else if (bus.clr_d)              d_d = 1'b0;

      if (bus.set_i)                   i_d = 1'b1;
      else if (bus.clr_i)              i_d = 1'b0;

      if (bus.flag_upd[UPD_Z]) z_d = bus.alu_zero;

      if (bus.set_c)                   c_d = 1'b1;
      else if (bus.clr_c)              c_d = 1'b0;
      else if (bus.flag_upd[UPD_C])    c_d = bus.alu_c_out;
    end
  end

  // Flag registers other than D
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  generate
    if (CLR_D_ON_RESET) begin : g_d_clr
      // D cleared by reset (CMOS behaviour)
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_q <= 1'b0;
        else          d_q <= d_d;
      end
    end else begin : g_d_keep
      // D frozen through reset (NMOS behaviour)
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_q <= d_q;
        else          d_q <= d_d;
      end
    end

    if (I_MASK_DELAY == 0) begin : g_irq_direct
      assign bus.irq_mask = i_q;
    end else begin : g_irq_delay
      logic irq_q;
      // Mask lags I by one cycle so CLI lets one more instruction run
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b1;
        else          irq_q <= i_q;
      end
      assign bus.irq_mask = irq_q;
    end
  endgenerate

  assign bus.p_out = {n_q, v_q, 1'b1, bus.push_b, d_q, i_q, z_q, c_q};
  assign bus.c_in  = c_q;
  assign bus.bcd   = d_q;

  // Branch condition from registered flags only
  always_comb begin
    bus.branch_taken = 1'b0;
    case (bus.cond_sel)
      2'd0:    bus.branch_taken = (n_q == bus.cond_val);
      2'd1:    bus.branch_taken = (v_q == bus.cond_val);
      2'd2:    bus.branch_taken = (c_q == bus.cond_val);
      default: bus.branch_taken = (z_q == bus.cond_val);
    endcase
  end

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: byte-level model plus directed vectors.
module tb_status_reg;
  localparam bit          CLR_D = 1'b1;
  localparam int unsigned IDLY  = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  status_reg_if bus ();

  status_reg #(.CLR_D_ON_RESET(CLR_D), .I_MASK_DELAY(IDLY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int conflicts = 0;
  bit chk_en = 1'b0;

  // Model state: P as a byte (bit5=1, bit4 stored as 0), and I as of the previous edge
  logic [7:0] m_p = 8'h24;
  logic       m_i_prev = 1'b1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic resolve(input logic cur, input logic s, input logic c,
                                   input logic u, input logic alu);
    if (s)      return 1'b1;
    else if (c) return 1'b0;
    else if (u) return alu;
    return cur;
  endfunction

  // Behavioural model of P
  always @(posedge clk or negedge reset_n) begin
    logic [7:0] nxt;
    if (!reset_n) begin
      m_p      = {4'b0010, (CLR_D ? 1'b0 : m_p[3]), 3'b100};
      m_i_prev = 1'b1;
    end else begin
      m_i_prev = m_p[2];
      nxt = m_p;
      if (bus.ld_p) begin
        nxt = (bus.db_in & 8'hCF) | 8'h20;
      end else begin
        nxt[7] = resolve(m_p[7], 1'b0,      1'b0,      bus.flag_upd[3], bus.alu_negative);
        nxt[6] = resolve(m_p[6], 1'b0,      bus.clr_v, bus.flag_upd[2], bus.alu_overflow);
        nxt[3] = resolve(m_p[3], bus.set_d, bus.clr_d, 1'b0,            1'b0);
        nxt[2] = resolve(m_p[2], bus.set_i, bus.clr_i, 1'b0,            1'b0);
        nxt[1] = resolve(m_p[1], 1'b0,      1'b0,      bus.flag_upd[1], bus.alu_zero);
        nxt[0] = resolve(m_p[0], bus.set_c, bus.clr_c, bus.flag_upd[0], bus.alu_c_out);
      end
      m_p = nxt;
    end
  end

  // Note simultaneous set/clr requests
  always @(posedge clk) begin
    if (reset_n && bus.set_c && bus.clr_c) begin
      conflicts++;
      $display("note: SEC and CLC asserted together at %0t", $time);
    end
    if (reset_n && bus.set_i && bus.clr_i) $display("note: SEI and CLI asserted together at %0t", $time);
    if (reset_n && bus.set_d && bus.clr_d) $display("note: SED and CLD asserted together at %0t", $time);
  end

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    logic [7:0] exp_p;
    logic       flag;
    if (chk_en) begin
      exp_p = m_p;
      exp_p[4] = bus.push_b;
      exp_p[5] = 1'b1;
      case (bus.cond_sel)
        2'd0:    flag = m_p[7];
        2'd1:    flag = m_p[6];
        2'd2:    flag = m_p[0];
        default: flag = m_p[1];
      endcase
      check("p_out",        bus.p_out,                    exp_p);
      check("c_in",         8'(bus.c_in),                 8'(m_p[0]));
      check("bcd",          8'(bus.bcd),                  8'(m_p[3]));
      check("irq_mask",     8'(bus.irq_mask),             8'((IDLY != 0) ? m_i_prev : m_p[2]));
      check("branch_taken", 8'(bus.branch_taken),         8'(flag == bus.cond_val));
    end
  end

  task automatic idle();
    bus.alu_zero = 1'b0; bus.alu_negative = 1'b0; bus.alu_overflow = 1'b0; bus.alu_c_out = 1'b0;
    bus.flag_upd = 4'b0; bus.ld_p = 1'b0; bus.db_in = 8'h00;
    bus.set_c = 1'b0; bus.clr_c = 1'b0; bus.set_i = 1'b0; bus.clr_i = 1'b0;
    bus.set_d = 1'b0; bus.clr_d = 1'b0; bus.clr_v = 1'b0;
    bus.push_b = 1'b0; bus.cond_sel = 2'd0; bus.cond_val = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] b);
    bus.ld_p = 1'b1; bus.db_in = b;
    tick();
    bus.ld_p = 1'b0; bus.db_in = 8'h00;
  endtask

  initial begin
    logic [7:0] rnd;
    idle();
    tick(); tick();
    chk_en = 1'b1;
    check("reset p_out", bus.p_out, 8'h24);
    check("reset irq",   8'(bus.irq_mask), 8'h01);
    reset_n = 1'b1;
    tick();

    // ALU capture of Z and C only
    bus.alu_zero = 1'b1; bus.alu_negative = 1'b1; bus.alu_overflow = 1'b1; bus.alu_c_out = 1'b1;
    bus.flag_upd = 4'b0011;
    tick();
    idle();
    check("alu zc p_out", bus.p_out, 8'h27);
    check("alu zc c_in",  8'(bus.c_in), 8'h01);

    // Bus load outranks set/clr
    bus.ld_p = 1'b1; bus.db_in = 8'hC3; bus.set_i = 1'b1; bus.clr_c = 1'b1; bus.push_b = 1'b1;
    tick();
    idle();
    bus.push_b = 1'b1;
    #1 check("ld_p push_b=1", bus.p_out, 8'hF3);
    bus.push_b = 1'b0;
    #1 check("ld_p push_b=0", bus.p_out, 8'hE3);

    // set/clr conflict on C, then CLV against ALU overflow
    bus.clr_c = 1'b1;
    tick();
    idle();
    check("clc", 8'(bus.c_in), 8'h00);
    bus.set_c = 1'b1; bus.clr_c = 1'b1;
    tick();
    idle();
    check("sec+clc", 8'(bus.c_in), 8'h01);
    check("conflict seen", 8'(conflicts), 8'h01);
    bus.clr_v = 1'b1; bus.flag_upd = 4'b0100; bus.alu_overflow = 1'b1;
    tick();
    idle();
    check("clv over alu", bus.p_out, 8'hA3);

    // SEC with ALU capture: C forced, N/Z taken from ALU
    bus.set_c = 1'b1; bus.flag_upd = 4'b1011; bus.alu_c_out = 1'b0;
    bus.alu_negative = 1'b0; bus.alu_zero = 1'b0;
    tick();
    idle();
    check("sec+upd", bus.p_out, 8'h21);

    // D flag
    bus.set_d = 1'b1;
    tick();
    idle();
    check("sed bcd", 8'(bus.bcd), 8'h01);

    // I change and delayed irq_mask
    bus.set_i = 1'b1;
    tick();
    idle();
    check("sei I",        8'(bus.p_out[2]), 8'h01);
    check("sei irq lag",  8'(bus.irq_mask), 8'h00);
    tick();
    check("sei irq",      8'(bus.irq_mask), 8'h01);
    bus.clr_i = 1'b1;
    tick();
    idle();
    check("cli I",        8'(bus.p_out[2]), 8'h00);
    check("cli irq lag",  8'(bus.irq_mask), 8'h01);
    tick();
    check("cli irq",      8'(bus.irq_mask), 8'h00);

    // Branch conditions
    load(8'h02);
    bus.cond_sel = 2'd3; bus.cond_val = 1'b1;
    #1 check("beq taken", 8'(bus.branch_taken), 8'h01);
    bus.cond_val = 1'b0;
    #1 check("bne not taken", 8'(bus.branch_taken), 8'h00);
    // Update in flight must not show in branch_taken until after the edge
    bus.flag_upd = 4'b0010; bus.alu_zero = 1'b0; bus.cond_val = 1'b1;
    #1 check("beq pre-edge", 8'(bus.branch_taken), 8'h01);
    tick();
    idle();
    bus.cond_sel = 2'd3; bus.cond_val = 1'b1;
    #1 check("beq post-edge", 8'(bus.branch_taken), 8'h00);
    for (int r = 0; r < 4; r++) begin
      rnd = 8'($urandom);
      load(rnd);
      for (int s = 0; s < 4; s++) begin
        for (int v = 0; v < 2; v++) begin
          bus.cond_sel = 2'(s); bus.cond_val = 1'(v);
          @(negedge clk);
          #1;
        end
      end
      idle();
    end

    // Reset mid-stream discards a pending load
    load(8'hFF);
    check("load ff", bus.p_out, 8'hEF);
    reset_n = 1'b0;
    #1;
    check("async rst p_out", bus.p_out, 8'h24);
    check("async rst irq",   8'(bus.irq_mask), 8'h01);
    check("async rst c_in",  8'(bus.c_in), 8'h00);
    check("async rst bcd",   8'(bus.bcd), 8'h00);
    bus.ld_p = 1'b1; bus.db_in = 8'hFF;
    tick();
    idle();
    check("rst hold", bus.p_out, 8'h24);
    reset_n = 1'b1;
    tick();
    check("post rst", bus.p_out, 8'h24);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
